// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer
//   Circular FIFO between the fetch stage and decode. Each entry holds an
//   instruction word and its PC tag. Back-pressure (stall_req) is raised early
//   enough that SKID in-flight fetches still find a free slot.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   in_instr/in_tag   : fetched instruction and its PC, qualified by in_valid
//   flush             : redirect, empties the buffer and discards the incoming entry
//   stall_req         : back-pressure to fetch, high when count >= DEPTH-SKID
//   out_instr/out_tag : head entry, qualified by out_valid, consumed with out_ready
//   count             : current occupancy
//   overflow_err      : sticky, set when a push is dropped on a full buffer
module instr_fetch_buffer #(
   parameter int DEPTH     = 4,
   parameter int INSTR_LEN = 32,
   parameter int XLEN      = 32,
   parameter int SKID      = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [INSTR_LEN-1:0]     in_instr,
   input  logic                     in_valid,
   input  logic [XLEN-1:0]          in_tag,
   input  logic                     flush,
   output logic                     stall_req,
   output logic [INSTR_LEN-1:0]     out_instr,
   output logic [XLEN-1:0]          out_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
   localparam logic [CW-1:0] STALL_TH_C = CW'(DEPTH - SKID);

   logic [INSTR_LEN-1:0] mem_instr [DEPTH];
   logic [XLEN-1:0]      mem_tag   [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;

   logic push, pop, drop;

   always_comb begin
      pop  = (count_q != '0) && out_ready && !flush;
      // A full buffer still accepts a push when the head leaves in the same cycle.
      push = in_valid && !flush && ((count_q < DEPTH_C) || pop);
      drop = in_valid && !flush && (count_q == DEPTH_C) && !pop;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q | drop;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointers are PW bits wide and DEPTH is a power of two, so +1 wraps.
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is deliberately not reset; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[wr_ptr_q] <= in_instr;
         mem_tag[wr_ptr_q]   <= in_tag;
      end
   end

   assign out_valid    = (count_q != '0);
   assign out_instr    = mem_instr[rd_ptr_q];
   assign out_tag      = mem_tag[rd_ptr_q];
   assign count        = count_q;
   assign stall_req    = (count_q >= STALL_TH_C);
   assign overflow_err = ovf_q;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
module tb_instr_fetch_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_instr;
   logic        in_valid;
   logic [31:0] in_tag;
   logic        flush;
   logic        stall_req;
   logic [31:0] out_instr;
   logic [31:0] out_tag;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  count;
   logic        overflow_err;

   int checks = 0;
   int errors = 0;

   instr_fetch_buffer #(.DEPTH(4), .INSTR_LEN(32), .XLEN(32), .SKID(2)) dut (
      .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid),
      .in_tag(in_tag), .flush(flush), .stall_req(stall_req),
      .out_instr(out_instr), .out_tag(out_tag), .out_valid(out_valid),
      .out_ready(out_ready), .count(count), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] t);
      return t ^ 32'hC0DE_0000;
   endfunction

   task automatic drive_push(input logic [31:0] t);
      in_valid = 1'b1;
      in_tag   = t;
      in_instr = instr_of(t);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_tag = '0; in_instr = '0;
      flush = 1'b0; out_ready = 1'b0;
      #3;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_stall", 64'(stall_req), 64'd0);
      chk("rst_ovf", 64'(overflow_err), 64'd0);
      #9 rst = 1'b0;

      // Fill with out_ready low; head must stay on 0x100 throughout.
      drive_push(32'h100); tick();
      chk("fill1_count", 64'(count), 64'd1);
      chk("fill1_valid", 64'(out_valid), 64'd1);
      chk("fill1_tag", 64'(out_tag), 64'h100);
      chk("fill1_instr", 64'(out_instr), 64'(instr_of(32'h100)));
      chk("fill1_stall", 64'(stall_req), 64'd0);
      drive_push(32'h104); tick();
      chk("fill2_count", 64'(count), 64'd2);
      chk("fill2_stall", 64'(stall_req), 64'd1);
      chk("fill2_tag", 64'(out_tag), 64'h100);
      drive_push(32'h108); tick();
      chk("fill3_count", 64'(count), 64'd3);
      drive_push(32'h10C); tick();
      chk("fill4_count", 64'(count), 64'd4);
      chk("fill4_ovf", 64'(overflow_err), 64'd0);
      chk("fill4_tag", 64'(out_tag), 64'h100);

      // Overflow: dropped push, sticky flag.
      drive_push(32'h110); tick();
      chk("ovf_count", 64'(count), 64'd4);
      chk("ovf_flag", 64'(overflow_err), 64'd1);
      chk("ovf_tag", 64'(out_tag), 64'h100);
      in_valid = 1'b0; tick();
      chk("ovf_sticky", 64'(overflow_err), 64'd1);
      chk("ovf_count2", 64'(count), 64'd4);

      // Drain in order; stall falls once count drops below 2.
      out_ready = 1'b1;
      chk("drain0_tag", 64'(out_tag), 64'h100);
      tick();
      chk("drain1_tag", 64'(out_tag), 64'h104);
      chk("drain1_stall", 64'(stall_req), 64'd1);
      tick();
      chk("drain2_tag", 64'(out_tag), 64'h108);
      chk("drain2_instr", 64'(out_instr), 64'(instr_of(32'h108)));
      chk("drain2_stall", 64'(stall_req), 64'd1);
      tick();
      chk("drain3_tag", 64'(out_tag), 64'h10C);
      chk("drain3_stall", 64'(stall_req), 64'd0);
      tick();
      chk("drain4_valid", 64'(out_valid), 64'd0);
      chk("drain4_count", 64'(count), 64'd0);
      chk("drain_ovf_sticky", 64'(overflow_err), 64'd1);

      // Asynchronous reset between edges with count=2.
      out_ready = 1'b0;
      drive_push(32'h300); tick();
      drive_push(32'h304); tick();
      in_valid = 1'b0;
      chk("prerst_count", 64'(count), 64'd2);
      #2 rst = 1'b1;
      #1;
      chk("arst_count", 64'(count), 64'd0);
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_stall", 64'(stall_req), 64'd0);
      chk("arst_ovf", 64'(overflow_err), 64'd0);
      #2 rst = 1'b0;
      drive_push(32'h0); tick();
      chk("postrst_valid", 64'(out_valid), 64'd1);
      chk("postrst_tag", 64'(out_tag), 64'h0);
      chk("postrst_instr", 64'(out_instr), 64'(instr_of(32'h0)));
      chk("postrst_count", 64'(count), 64'd1);
      in_valid = 1'b0; out_ready = 1'b1; tick();
      chk("postrst_empty", 64'(out_valid), 64'd0);

      // Simultaneous push and pop on a full buffer; also exercises pointer wrap.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_push(32'h100 + 32'(4 * i)); tick();
      end
      chk("pp_pre_count", 64'(count), 64'd4);
      drive_push(32'h200); out_ready = 1'b1; tick();
      chk("pp_count", 64'(count), 64'd4);
      chk("pp_ovf", 64'(overflow_err), 64'd0);
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         logic [31:0] exp_tag;
         exp_tag = (i == 3) ? 32'h200 : 32'h104 + 32'(4 * i);
         chk("pp_order_tag", 64'(out_tag), 64'(exp_tag));
         chk("pp_order_instr", 64'(out_instr), 64'(instr_of(exp_tag)));
         tick();
      end
      chk("pp_empty", 64'(out_valid), 64'd0);
      chk("pp_ovf_end", 64'(overflow_err), 64'd0);

      // Flush wins over a same-cycle push and pop.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_push(32'h400 + 32'(4 * i)); tick();
      end
      chk("fl_pre_count", 64'(count), 64'd3);
      drive_push(32'h4FF); out_ready = 1'b1; flush = 1'b1; tick();
      chk("fl_count", 64'(count), 64'd0);
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_stall", 64'(stall_req), 64'd0);
      flush = 1'b0; in_valid = 1'b0; tick();
      chk("fl_after_valid", 64'(out_valid), 64'd0);
      chk("fl_after_count", 64'(count), 64'd0);
      chk("fl_ovf", 64'(overflow_err), 64'd0);

      // After flush, a fresh push lands at pointer 0 and is the head.
      drive_push(32'h500); tick();
      in_valid = 1'b0;
      chk("fl_refill_tag", 64'(out_tag), 64'h500);
      chk("fl_refill_count", 64'(count), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
